// File: rtl/step_counter.sv
// Up/down step counter with wrap/saturate range [LO,HI], boundary pulse and sticky overflow.
// Define STEP_COUNTER_EVTCNT_EN to add the saturating 8-bit event counter output evt_cnt.
module step_counter #(
  parameter int unsigned    W  = 32,
  parameter logic [W-1:0]   IV = '0,
  parameter logic [W-1:0]   LO = '0,
  parameter logic [W-1:0]   HI = {W{1'b1}}
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic         en,
  input  logic         up,
  input  logic [W-1:0] step,
  input  logic         sat,
  input  logic         ld,
  input  logic [W-1:0] ld_val,
  input  logic         clr_ovf,
  output logic [W-1:0] q,
  output logic         tc,
  output logic         at_lo,
  output logic         at_hi,
  output logic         ovf
`ifdef STEP_COUNTER_EVTCNT_EN
  ,
  output logic [7:0]   evt_cnt
`endif
);

  localparam logic [W:0] WLO = {1'b0, LO};
  localparam logic [W:0] WHI = {1'b0, HI};
  localparam logic [W:0] ONE = {{W{1'b0}}, 1'b1};

  logic [W-1:0] q_q, q_d;
  logic         tc_q, tc_d;
  logic         ovf_q, ovf_d;
  logic [W:0]   wq, ws, sum, nxt_w;
  logic         wrap_evt, evt;

  // One extra bit so q+step and LO+step never overflow before the bound compare.
  always_comb begin
    wq       = {1'b0, q_q};
    ws       = {1'b0, step};
    sum      = wq + ws;
    nxt_w    = wq;
    wrap_evt = 1'b0;
    if (up) begin
      if (sum > WHI) begin
        wrap_evt = 1'b1;
        nxt_w    = sat ? WHI : (WLO + (sum - WHI - ONE));
      end else begin
        nxt_w = sum;
      end
    end else begin
      if (wq >= (WLO + ws)) begin
        nxt_w = wq - ws;
      end else begin
        wrap_evt = 1'b1;
        nxt_w    = sat ? WLO : (WHI - (WLO + ws - wq - ONE));
      end
    end
  end

  always_comb begin
    q_d = q_q;
    evt = 1'b0;
    if (ld) begin
      if (ld_val < LO)      q_d = LO;
      else if (ld_val > HI) q_d = HI;
      else                  q_d = ld_val;
    end else if (en) begin
      q_d = nxt_w[W-1:0];
      evt = wrap_evt;
    end
    tc_d  = evt;
    // A same-cycle event beats the clear.
    ovf_d = evt | (ovf_q & ~clr_ovf);
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      q_q   <= IV;
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      tc_q  <= tc_d;
      ovf_q <= ovf_d;
    end
  end

`ifdef STEP_COUNTER_EVTCNT_EN
  logic [7:0] evt_cnt_q, evt_cnt_d;

  always_comb begin
    evt_cnt_d = evt_cnt_q;
    if (clr_ovf)                        evt_cnt_d = 8'd0;
    else if (evt && evt_cnt_q != 8'hFF) evt_cnt_d = evt_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_b) evt_cnt_q <= 8'd0;
    else        evt_cnt_q <= evt_cnt_d;
  end

  assign evt_cnt = evt_cnt_q;
`endif

  assign q     = q_q;
  assign tc    = tc_q;
  assign ovf   = ovf_q;
  assign at_lo = (q_q == LO);
  assign at_hi = (q_q == HI);

endmodule

// File: tb/tb_step_counter.sv
// Bench for step_counter: vector table through a scoreboard queue on two instances
// (full range and LO=10/HI=50), then a short random run on the narrow instance.
module tb_step_counter;

  logic       clk = 1'b0;
  logic       rst_b, en, up, sat, ld, clr_ovf;
  logic [7:0] step, ld_val;
  logic [7:0] qa, qb;
  logic       tca, tcb, loa, lob, hia, hib, ovfa, ovfb;
`ifdef STEP_COUNTER_EVTCNT_EN
  logic [7:0] eca, ecb;
`endif

  always #5 clk = ~clk;

  step_counter #(.W(8), .IV(8'd100), .LO(8'd0), .HI(8'd255)) dut_a (
    .clk(clk), .rst_b(rst_b), .en(en), .up(up), .step(step), .sat(sat),
    .ld(ld), .ld_val(ld_val), .clr_ovf(clr_ovf),
    .q(qa), .tc(tca), .at_lo(loa), .at_hi(hia), .ovf(ovfa)
`ifdef STEP_COUNTER_EVTCNT_EN
    , .evt_cnt(eca)
`endif
  );

  step_counter #(.W(8), .IV(8'd10), .LO(8'd10), .HI(8'd50)) dut_b (
    .clk(clk), .rst_b(rst_b), .en(en), .up(up), .step(step), .sat(sat),
    .ld(ld), .ld_val(ld_val), .clr_ovf(clr_ovf),
    .q(qb), .tc(tcb), .at_lo(lob), .at_hi(hib), .ovf(ovfb)
`ifdef STEP_COUNTER_EVTCNT_EN
    , .evt_cnt(ecb)
`endif
  );

  typedef struct {
    logic       rst_b, en, up, sat, ld, clr;
    logic [7:0] step, ld_val;
    logic       sel;                 // 0: dut_a, 1: dut_b
    logic [7:0] q;
    logic       tc, lo, hi, ovf;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   errors = 0;
  int   checks = 0;

  function automatic vec_t mk(logic r, logic e, logic u, logic [7:0] s, logic sa,
                              logic l, logic [7:0] lv, logic c, logic sel,
                              logic [7:0] q, logic tc, logic lo, logic hi, logic ovf);
    vec_t v;
    v.rst_b = r; v.en = e; v.up = u; v.step = s; v.sat = sa; v.ld = l;
    v.ld_val = lv; v.clr = c; v.sel = sel;
    v.q = q; v.tc = tc; v.lo = lo; v.hi = hi; v.ovf = ovf;
    return v;
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive on the falling edge, push expectation, pop and compare after the rising edge.
  task automatic apply(vec_t v, int idx);
    vec_t e;
    @(negedge clk);
    rst_b = v.rst_b; en = v.en; up = v.up; step = v.step; sat = v.sat;
    ld = v.ld; ld_val = v.ld_val; clr_ovf = v.clr;
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    if (!e.sel) begin
      chk($sformatf("v%0d.q", idx), qa, e.q);
      chk($sformatf("v%0d.tc", idx), tca, e.tc);
      chk($sformatf("v%0d.at_lo", idx), loa, e.lo);
      chk($sformatf("v%0d.at_hi", idx), hia, e.hi);
      chk($sformatf("v%0d.ovf", idx), ovfa, e.ovf);
    end else begin
      chk($sformatf("v%0d.q", idx), qb, e.q);
      chk($sformatf("v%0d.tc", idx), tcb, e.tc);
      chk($sformatf("v%0d.at_lo", idx), lob, e.lo);
      chk($sformatf("v%0d.at_hi", idx), hib, e.hi);
      chk($sformatf("v%0d.ovf", idx), ovfb, e.ovf);
    end
  endtask

  initial begin
    int mq, mtc, movf, s, st, lo, hi;
    vec_t r;
    rst_b = 1'b0; en = 0; up = 0; sat = 0; ld = 0; clr_ovf = 0; step = 0; ld_val = 0;

    //             rst en up step sat ld  ldv clr sel   q  tc lo hi ovf
    vecs.push_back(mk(0, 0, 0, 8'd0, 0, 0, 8'd0,   0, 0, 8'd100, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 8'd5, 0, 0, 8'd0,   0, 0, 8'd95,  0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 8'd5, 0, 0, 8'd0,   0, 0, 8'd90,  0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 8'd5, 0, 0, 8'd0,   0, 0, 8'd85,  0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 8'd5, 0, 1, 8'd3,   0, 0, 8'd3,   0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 8'd5, 0, 0, 8'd0,   0, 0, 8'd254, 1, 0, 0, 1));
    vecs.push_back(mk(1, 0, 0, 8'd5, 0, 0, 8'd0,   0, 0, 8'd254, 0, 0, 0, 1));
    vecs.push_back(mk(1, 0, 1, 8'd5, 0, 1, 8'd253, 0, 0, 8'd253, 0, 0, 0, 1));
    vecs.push_back(mk(1, 1, 1, 8'd5, 0, 0, 8'd0,   0, 0, 8'd2,   1, 0, 0, 1));
    vecs.push_back(mk(1, 0, 1, 8'd5, 1, 1, 8'd253, 0, 0, 8'd253, 0, 0, 0, 1));
    vecs.push_back(mk(1, 1, 1, 8'd5, 1, 0, 8'd0,   0, 0, 8'd255, 1, 0, 1, 1));
    vecs.push_back(mk(1, 1, 1, 8'd5, 1, 0, 8'd0,   0, 0, 8'd255, 1, 0, 1, 1));
    vecs.push_back(mk(1, 0, 1, 8'd5, 1, 0, 8'd0,   1, 0, 8'd255, 0, 0, 1, 0));
    vecs.push_back(mk(1, 1, 1, 8'd0, 1, 0, 8'd0,   0, 0, 8'd255, 0, 0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 8'd5, 0, 1, 8'd5,   0, 0, 8'd5,   0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 8'd5, 0, 0, 8'd0,   0, 0, 8'd0,   0, 1, 0, 0));
    vecs.push_back(mk(1, 1, 0, 8'd5, 1, 0, 8'd0,   0, 0, 8'd0,   1, 1, 0, 1));
    vecs.push_back(mk(1, 1, 0, 8'd5, 0, 0, 8'd0,   1, 0, 8'd251, 1, 0, 0, 1));
    vecs.push_back(mk(1, 0, 0, 8'd5, 0, 0, 8'd0,   1, 0, 8'd251, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 1, 8'd5, 0, 1, 8'd250, 0, 0, 8'd250, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 1, 8'd5, 0, 0, 8'd0,   0, 0, 8'd255, 0, 0, 1, 0));
    vecs.push_back(mk(1, 1, 1, 8'd1, 0, 0, 8'd0,   0, 0, 8'd0,   1, 1, 0, 1));
    vecs.push_back(mk(0, 1, 1, 8'd1, 0, 1, 8'd7,   0, 0, 8'd100, 0, 0, 0, 0));
    // narrow-range instance
    vecs.push_back(mk(0, 0, 0, 8'd5, 0, 0, 8'd0,   0, 1, 8'd10,  0, 1, 0, 0));
    vecs.push_back(mk(1, 1, 0, 8'd5, 0, 0, 8'd0,   0, 1, 8'd46,  1, 0, 0, 1));
    vecs.push_back(mk(1, 0, 0, 8'd5, 0, 1, 8'd60,  0, 1, 8'd50,  0, 0, 1, 1));
    vecs.push_back(mk(1, 0, 0, 8'd5, 0, 1, 8'd0,   0, 1, 8'd10,  0, 1, 0, 1));
    vecs.push_back(mk(1, 1, 1, 8'd41, 0, 0, 8'd0,  0, 1, 8'd10,  1, 1, 0, 1));
    vecs.push_back(mk(1, 1, 1, 8'd40, 1, 0, 8'd0,  1, 1, 8'd50,  0, 0, 1, 0));

    foreach (vecs[i]) apply(vecs[i], i);

`ifdef STEP_COUNTER_EVTCNT_EN
    apply(mk(0, 1, 1, 8'd1, 0, 1, 8'd7, 0, 1, 8'd10, 0, 1, 0, 0), 100);
    chk("evt_cnt_a_rst", eca, 0);
    chk("evt_cnt_b_rst", ecb, 0);
`endif

    // Random run on the narrow instance against a behavioural model.
    lo = 10; hi = 50;
    apply(mk(0, 0, 0, 8'd0, 0, 0, 8'd0, 0, 1, 8'd10, 0, 1, 0, 0), 200);
    mq = 10; mtc = 0; movf = 0;
    for (int n = 0; n < 60; n++) begin
      r.rst_b = 1'b1;
      r.en = ($urandom_range(0, 3) != 0);
      r.up = $urandom_range(0, 1);
      r.sat = $urandom_range(0, 1);
      r.ld = ($urandom_range(0, 7) == 0);
      r.clr = ($urandom_range(0, 5) == 0);
      st = $urandom_range(0, 41);
      r.step = st[7:0];
      s = $urandom_range(0, 70);
      r.ld_val = s[7:0];
      r.sel = 1'b1;
      mtc = 0;
      if (r.ld) mq = (s < lo) ? lo : (s > hi) ? hi : s;
      else if (r.en) begin
        if (r.up) begin
          if (mq + st > hi) begin mtc = 1; mq = r.sat ? hi : lo + (mq + st - hi - 1); end
          else mq = mq + st;
        end else begin
          if (mq - st >= lo) mq = mq - st;
          else begin mtc = 1; mq = r.sat ? lo : hi - (lo + st - mq - 1); end
        end
      end
      movf = mtc ? 1 : (r.clr ? 0 : movf);
      r.q = mq[7:0]; r.tc = mtc[0]; r.ovf = movf[0];
      r.lo = (mq == lo); r.hi = (mq == hi);
      apply(r, 300 + n);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/step_counter.md
Name: step_counter

Overview:
Parametrised up/down counter with a runtime-programmable step, synchronous load, and a selectable wrap or saturate mode within a configurable range [LO, HI]. It generalises the fixed down-by-5 counter. Typical uses are countdown timers, address strides and credit counters. It emits a boundary pulse, level flags for each bound, and a sticky overflow flag for control FSMs.

Parameters:
W, 32, counter/step/load width in bits
IV, 0, reset value of q; must satisfy LO <= IV <= HI
LO, 0, lower range bound
HI, 2**W-1, upper range bound; LO < HI required

Ports:
clk  input  1  clock, rising edge
rst_b  input  1  synchronous active-low reset
en  input  1  count enable; one step per cycle while high
up  input  1  direction: 1 = add step, 0 = subtract step
step  input  W  step size; legal 1..(HI-LO+1); 0 = hold
sat  input  1  mode: 1 = saturate at bounds, 0 = wrap within [LO,HI]
ld  input  1  synchronous load strobe
ld_val  input  W  load value
clr_ovf  input  1  clears sticky ovf
q  output  W  counter value (registered)
tc  output  1  registered one-cycle pulse: the last update wrapped or saturated
at_lo  output  1  combinational, q == LO
at_hi  output  1  combinational, q == HI
ovf  output  1  sticky: set on any wrap or saturation event

Behaviour:
- All state updates on the rising edge of clk. Priority: rst_b low > ld > en.
- Reset (rst_b=0 at edge): q=IV, tc=0, ovf=0. at_lo and at_hi follow from IV.
- Load (ld=1): q=ld_val clamped into range (ld_val<LO -> LO, ld_val>HI -> HI). tc=0. ovf unchanged, except clr_ovf still applies. en is ignored in that cycle.
- Count (en=1, ld=0). All arithmetic is done in W+1 bits, with no intermediate overflow.
  - Up, sum = q+step:
    - sum <= HI: q=sum.
    - sum > HI and sat=1: q=HI, event.
    - sum > HI and sat=0: q=LO+(sum-HI-1), event.
  - Down:
    - q >= LO+step: q=q-step.
    - Otherwise with sat=1: q=LO, event.
    - Otherwise with sat=0: q=HI-(LO+step-q-1), event.
  - Landing exactly on HI or LO without crossing is not an event.
  - Already saturated at a bound and stepping further outward is an event every cycle; q stays put.
- Event: tc=1 for the cycle following the edge, in the same cycle q shows the new value. Otherwise tc=0. tc clears on any non-event cycle, including en=0.
- ovf: set on any event. Cleared when clr_ovf=1 and no event in the same cycle; a simultaneous event wins (ovf stays 1).
- en=0 and ld=0: q holds, tc=0.
- step=0 with en=1: q holds, no event.
- step > HI-LO+1 is illegal; the result is undefined but must not produce X.
- Reset mid-count: rst_b dominates ld/en in the same edge. No partial updates.
- Latency: one cycle from en/ld to q. at_lo and at_hi have zero latency from q.

Optional Feature:
Macro STEP_COUNTER_EVTCNT_EN.
- Defined: adds output evt_cnt [7:0]. It counts events, saturates at 255, and is cleared by reset and by clr_ovf (clr_ovf wins over a simultaneous event for evt_cnt only).
- Undefined: no evt_cnt port and no associated logic; all other behaviour is identical.

Test Plan:
- Parameters W=8, IV=100, LO=0, HI=255 for all scenarios.
- Reset then en=1, up=0, step=5, sat=0 for 3 cycles -> q = 100, 95, 90, 85; tc=0; ovf=0.
- ld=1, ld_val=3 with en=1 same cycle -> q=3 (load wins). Next: up=0, step=5, sat=0 -> q=254, tc=1 for one cycle, ovf=1.
- ld_val=253, up=1, step=5, sat=0 -> q=2, tc=1. Repeat with sat=1 -> q=255, at_hi=1, tc=1. The next en cycle keeps q=255 with tc=1 again.
- Re-instantiate with LO=10, HI=50, IV=10, sat=0, up=0, step=5:
  - q=10, at_lo=1, then q=46, tc=1.
  - ld_val=60 -> q=50, at_hi=1.
  - ld_val=0 -> q=10.
- ovf set; clr_ovf=1 with no event -> ovf=0. clr_ovf=1 together with a wrap event -> ovf stays 1.
- rst_b=0 for one edge during counting with en=1, ld=1 -> q=100, tc=0, ovf=0. With STEP_COUNTER_EVTCNT_EN, evt_cnt=0.
